pbas_min_dist: RTL and testbench

// - PBAS per-pixel sample-match stage, directly upstream of the decision-threshold stage.
// - Consumes the N background-sample distances of one pixel as a serial stream.
// - Produces per pixel: the minimum distance (dmin), the count of samples closer than the

---
 rtl/pbas_pkg.sv | 26 ++
 rtl/pbas_min_cnt_acc.sv | 51 +++++
 rtl/pbas_min_dist.sv | 165 ++++++++++++++++
 tb/tb_pbas_min_dist.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pbas_pkg.sv
// Shared defaults and state encoding for the PBAS per-pixel sample-match stage.
// The counter width is derived from the sample count, so the counters always have room for N_SAMPLES.
package pbas_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_N_SAMPLES = 20;
  localparam int DEF_CNT_W     = clog2(DEF_N_SAMPLES + 1);
  localparam int DEF_MIN_MATCH = 2;

  localparam logic IDLE = 1'b0;
  localparam logic ACC  = 1'b1;

endpackage

// File: rtl/pbas_min_cnt_acc.sv
// Running minimum and below-threshold counter over one pixel's sample stream.
// The next-state values are exported so the parent can register the result on the last beat.
module pbas_min_cnt_acc
  import pbas_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              step,
  input  logic [DATA_W-1:0] sdist,
  input  logic [DATA_W-1:0] thr,
  output logic [DATA_W-1:0] nxt_min,
  output logic [CNT_W-1:0]  nxt_cnt
);

  logic [DATA_W-1:0] run_min;
  logic [CNT_W-1:0]  run_cnt;
  logic              hit;

  // Next running min/count: init restarts from this sample, step folds it in.
  always_comb begin
    nxt_min = run_min;
    nxt_cnt = run_cnt;
    hit     = (sdist < thr);
    if (init) begin
      nxt_min = sdist;
      nxt_cnt = {{(CNT_W-1){1'b0}}, hit};
    end else if (step) begin
      nxt_min = (sdist < run_min) ? sdist : run_min;
      nxt_cnt = run_cnt + {{(CNT_W-1){1'b0}}, hit};
    end else begin
      nxt_min = run_min;
      nxt_cnt = run_cnt;
    end
  end

  // Accumulator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min <= {DATA_W{1'b1}};
      run_cnt <= {CNT_W{1'b0}};
    end else begin
      run_min <= nxt_min;
      run_cnt <= nxt_cnt;
    end
  end

endmodule

// File: rtl/pbas_min_dist.sv
// PBAS sample-match stage: per pixel, minimum distance, count of samples under R(x),
// foreground flag and the realigned threshold, one result strobe per completed pixel.
module pbas_min_dist
  import pbas_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MIN_MATCH = DEF_MIN_MATCH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sv,
  input  logic              sfirst,
  input  logic [DATA_W-1:0] sdist,
  input  logic [DATA_W-1:0] rx,
  output logic              ov,
  output logic [DATA_W-1:0] dmin,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              fg,
  output logic [DATA_W-1:0] rx_o,
  output logic              err
);

  if ((2 ** CNT_W) <= N_SAMPLES) begin : g_bad_cnt_w
    $error("pbas_min_dist: CNT_W too small for N_SAMPLES");
  end
  if ((MIN_MATCH > N_SAMPLES) || (MIN_MATCH < 1)) begin : g_bad_min_match
    $error("pbas_min_dist: MIN_MATCH out of range 1..N_SAMPLES");
  end
  if (N_SAMPLES < 2) begin : g_bad_n_samples
    $error("pbas_min_dist: N_SAMPLES must be at least 2");
  end

  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] MIN_MATCH_C = CNT_W'(MIN_MATCH);

  logic              state;
  logic              next_state;
  logic [CNT_W-1:0]  idx;
  logic [DATA_W-1:0] rx_hold;
  logic [DATA_W-1:0] thr;
  logic              last_beat;
  logic              acc_init;
  logic              acc_step;
  logic              emit;
  logic              err_next;
  logic [DATA_W-1:0] nxt_min;
  logic [CNT_W-1:0]  nxt_cnt;

  assign last_beat = (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: a first beat always (re)starts a pixel, the last sample closes it.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (sv && sfirst) next_state = ACC;
        else              next_state = IDLE;
      end
      ACC: begin
        if (sv && sfirst)         next_state = ACC;
        else if (sv && last_beat) next_state = IDLE;
        else                      next_state = ACC;
      end
      default: next_state = IDLE;
    endcase
  end

  // Per-state controls; a stray continuation in IDLE or a restart in ACC flags err.
  always_comb begin
    acc_init = 1'b0;
    acc_step = 1'b0;
    emit     = 1'b0;
    err_next = 1'b0;
    case (state)
      IDLE: begin
        acc_init = sv & sfirst;
        err_next = sv & ~sfirst;
      end
      ACC: begin
        acc_init = sv & sfirst;
        acc_step = sv & ~sfirst;
        emit     = sv & ~sfirst & last_beat;
        err_next = sv & sfirst;
      end
      default: begin
        acc_init = 1'b0;
        acc_step = 1'b0;
        emit     = 1'b0;
        err_next = 1'b0;
      end
    endcase
  end

  // The first beat compares against the live rx; later beats use the held copy.
  assign thr = acc_init ? rx : rx_hold;

  // Sample index and captured threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= {CNT_W{1'b0}};
      rx_hold <= {DATA_W{1'b0}};
    end else if (acc_init) begin
      idx     <= {{(CNT_W-1){1'b0}}, 1'b1};
      rx_hold <= rx;
    end else if (acc_step) begin
      idx     <= last_beat ? {CNT_W{1'b0}} : (idx + {{(CNT_W-1){1'b0}}, 1'b1});
      rx_hold <= rx_hold;
    end else begin
      idx     <= idx;
      rx_hold <= rx_hold;
    end
  end

  pbas_min_cnt_acc #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (acc_init),
    .step    (acc_step),
    .sdist   (sdist),
    .thr     (thr),
    .nxt_min (nxt_min),
    .nxt_cnt (nxt_cnt)
  );

  // Result register: captured with the last sample, held until the next pixel completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov        <= 1'b0;
      err       <= 1'b0;
      dmin      <= {DATA_W{1'b1}};
      match_cnt <= {CNT_W{1'b0}};
      fg        <= 1'b0;
      rx_o      <= {DATA_W{1'b0}};
    end else begin
      ov  <= emit;
      err <= err_next;
      if (emit) begin
        dmin      <= nxt_min;
        match_cnt <= nxt_cnt;
        fg        <= (nxt_cnt < MIN_MATCH_C);
        rx_o      <= rx_hold;
      end else begin
        dmin      <= dmin;
        match_cnt <= match_cnt;
        fg        <= fg;
        rx_o      <= rx_o;
      end
    end
  end

endmodule

// File: tb/tb_pbas_min_dist.sv
// Directed bench for pbas_min_dist: hand-computed pixels, bubbles, aborts, reset, and a
// back-to-back random run checked against a small min/count model.
module tb_pbas_min_dist;

  localparam int NS = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sv;
  logic        sfirst;
  logic [15:0] sdist;
  logic [15:0] rx;
  logic        ov;
  logic [15:0] dmin;
  logic [4:0]  match_cnt;
  logic        fg;
  logic [15:0] rx_o;
  logic        err;

  always #5 clk = ~clk;

  pbas_min_dist dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sv        (sv),
    .sfirst    (sfirst),
    .sdist     (sdist),
    .rx        (rx),
    .ov        (ov),
    .dmin      (dmin),
    .match_cnt (match_cnt),
    .fg        (fg),
    .rx_o      (rx_o),
    .err       (err)
  );

  typedef struct {
    logic [15:0] dmin;
    logic [4:0]  cnt;
    logic        fg;
    logic [15:0] rxo;
    int          cyc;
  } res_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          err_seen = 0;
  int          err_cyc = -1;
  res_t        got_q[$];
  res_t        exp_q[$];
  logic [15:0] pix[NS];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    res_t r;
    if (ov) begin
      r.dmin = dmin; r.cnt = match_cnt; r.fg = fg; r.rxo = rx_o; r.cyc = cyc;
      got_q.push_back(r);
    end
    if (err) begin
      err_seen++;
      err_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic [15:0] d, input logic [15:0] r);
    @(negedge clk);
    sv = v; sfirst = f; sdist = d; rx = r;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic push_exp(input logic [15:0] r, input int at_cyc);
    res_t e;
    e.dmin = 16'hFFFF;
    e.cnt  = 5'd0;
    for (int k = 0; k < NS; k++) begin
      if (pix[k] < e.dmin) e.dmin = pix[k];
      if (pix[k] < r) e.cnt = e.cnt + 5'd1;
    end
    e.fg  = (e.cnt < 5'd2);
    e.rxo = r;
    e.cyc = at_cyc;
    exp_q.push_back(e);
  endtask

  // Sends the first n_beats samples of pix; rx on non-first beats is deliberately wrong.
  task automatic send_pixel(input logic [15:0] r, input int gaps, input int n_beats, output int first_cyc);
    first_cyc = 0;
    for (int k = 0; k < n_beats; k++) begin
      drive(1'b1, (k == 0), pix[k], (k == 0) ? r : ~r);
      if (k == 0) first_cyc = cyc;
      if (k < n_beats - 1) begin
        repeat (gaps) drive(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      end
    end
    if (n_beats == NS) push_exp(r, cyc + 1);
  endtask

  task automatic flush_compare(input string tag);
    res_t g;
    res_t e;
    idle(2);
    chk({tag, "_ov_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_dmin"}, g.dmin, e.dmin);
      chk({tag, "_match_cnt"}, g.cnt, e.cnt);
      chk({tag, "_fg"}, g.fg, e.fg);
      chk({tag, "_rx_o"}, g.rxo, e.rxo);
      chk({tag, "_ov_cycle"}, g.cyc, e.cyc);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 10; k++) pix[k] = 16'(100 - 10 * k);
    for (int k = 10; k < NS; k++) pix[k] = 16'd5;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ov"}, ov, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_dmin"}, dmin, 16'hFFFF);
    chk({tag, "_match_cnt"}, match_cnt, 5'd0);
    chk({tag, "_fg"}, fg, 1'b0);
    chk({tag, "_rx_o"}, rx_o, 16'd0);
  endtask

  initial begin
    int fc;
    int e0;
    rst_n = 1'b0; sv = 1'b0; sfirst = 1'b0; sdist = 16'd0; rx = 16'd0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 100..10 then ten 5s, rx=30: matches are 20, 10 and the ten 5s -> 12.
    load_ramp();
    send_pixel(16'd30, 0, NS, fc);
    idle(1);
    chk("t1_dmin", dmin, 16'd5);
    chk("t1_match_cnt", match_cnt, 5'd12);
    chk("t1_fg", fg, 1'b0);
    chk("t1_rx_o", rx_o, 16'd30);
    flush_compare("t1");

    // sdist == rx is not a match.
    for (int k = 0; k < NS; k++) pix[k] = 16'd10;
    send_pixel(16'd10, 0, NS, fc);
    idle(1);
    chk("t2_match_cnt", match_cnt, 5'd0);
    chk("t2_fg", fg, 1'b1);
    chk("t2_dmin", dmin, 16'd10);
    flush_compare("t2");

    load_ramp();
    send_pixel(16'd30, 2, NS, fc);
    idle(1);
    chk("t3_dmin", dmin, 16'd5);
    chk("t3_match_cnt", match_cnt, 5'd12);
    chk("t3_fg", fg, 1'b0);
    flush_compare("t3");

    // Abort at beat 7 by a fresh first beat.
    e0 = err_seen;
    send_pixel(16'd30, 0, 6, fc);
    for (int k = 0; k < NS; k++) pix[k] = 16'd40;
    send_pixel(16'd50, 0, NS, fc);
    idle(1);
    chk("t4_err_count", err_seen - e0, 1);
    chk("t4_err_cycle", err_cyc, fc + 1);
    chk("t4_dmin", dmin, 16'd40);
    chk("t4_match_cnt", match_cnt, 5'd20);
    chk("t4_rx_o", rx_o, 16'd50);
    chk("t4_fg", fg, 1'b0);
    flush_compare("t4");

    // Reset in the middle of a pixel.
    load_ramp();
    send_pixel(16'd30, 0, 12, fc);
    @(negedge clk);
    rst_n = 1'b0; sv = 1'b0; sfirst = 1'b0;
    #1;
    check_reset_values("t5_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("t5_no_ov", got_q.size(), 0);
    send_pixel(16'd30, 0, NS, fc);
    idle(1);
    chk("t5_dmin", dmin, 16'd5);
    chk("t5_match_cnt", match_cnt, 5'd12);
    flush_compare("t5");

    // Continuation beat from IDLE: err only.
    e0 = err_seen;
    drive(1'b1, 1'b0, 16'd7, 16'd7);
    idle(2);
    chk("t6_idle_err", err_seen - e0, 1);
    chk("t6_idle_no_ov", got_q.size(), 0);

    for (int p = 0; p < 100; p++) begin
      logic [15:0] r;
      r = 16'($urandom_range(0, 200));
      for (int k = 0; k < NS; k++) begin
        pix[k] = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(0, 255));
      end
      send_pixel(r, 0, NS, fc);
    end
    flush_compare("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
